// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin share of the data bus between CPU MEM (m0) and DMA/debug (m1).
// Ports: clk/rst_n; m*_req/wen/addr/wdata in, m*_rdata/ack/err/stall out; s_* to the bridge.
// Optional: define DBUS_TIMEOUT_EN to abort a grant after TIMEOUT cycles without s_ready.
module dbus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          m1_stall,
  output logic [AW-1:0] s_addr,
  output logic          s_wen,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_gnt;
  logic   w_last_nxt;
  logic   w_to;
  logic   w_done;

`ifdef DBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Zero in the first grant cycle, so TO_LAST marks the TIMEOUT-th cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_to = (r_state != IDLE) && (r_cnt == TO_LAST) && !s_ready;
`else
  assign w_to = 1'b0;
`endif

  assign w_done = (r_state != IDLE) && (s_ready || w_to);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_gnt;
    s_addr      = '0;
    s_wen       = 1'b0;
    s_wdata     = '0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_err      = 1'b0;
    m1_err      = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    unique case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          w_state_nxt = r_last_gnt ? GNT0 : GNT1;
        end else if (m0_req) begin
          w_state_nxt = GNT0;
        end else if (m1_req) begin
          w_state_nxt = GNT1;
        end
      end
      GNT0: begin
        s_addr   = m0_addr;
        s_wen    = m0_wen & ~w_to;
        s_wdata  = m0_wdata;
        m0_ack   = w_done;
        m0_err   = w_to;
        m0_rdata = s_ready ? s_rdata : '0;
        if (w_done) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      GNT1: begin
        s_addr   = m1_addr;
        s_wen    = m1_wen & ~w_to;
        s_wdata  = m1_wdata;
        m1_ack   = w_done;
        m1_err   = w_to;
        m1_rdata = s_ready ? s_rdata : '0;
        if (w_done) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Stall is purely request-driven so it stays valid even while in reset.
  assign m0_stall = m0_req & ~m0_ack;
  assign m1_stall = m1_req & ~m1_ack;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed scenarios plus randomized two-master traffic
// checked by a scoreboard against a bus-ownership reference model.
module tb_dbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [1:0]    wen;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m0_err, m0_stall;
  logic          m1_ack, m1_err, m1_stall;
  logic [AW-1:0] s_addr;
  logic          s_wen;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (req[0]),
    .m0_wen   (wen[0]),
    .m0_addr  (addr[0]),
    .m0_wdata (wdata[0]),
    .m0_rdata (m0_rdata),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m0_stall (m0_stall),
    .m1_req   (req[1]),
    .m1_wen   (wen[1]),
    .m1_addr  (addr[1]),
    .m1_wdata (wdata[1]),
    .m1_rdata (m1_rdata),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .m1_stall (m1_stall),
    .s_addr   (s_addr),
    .s_wen    (s_wen),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard queues: drivers push, monitor pops when the model grants.
  txn_t q0[$];
  txn_t q1[$];
  txn_t cur;
  int   own      = -1;
  logic last     = 1'b1;
  bit   mon_en   = 1'b0;
  bit   rnd_done = 1'b0;

  // Reference model: one owner at a time; an idle bus goes to the sole
  // requester, or to the master not served last when both ask.
  task automatic mon_step();
    logic [1:0] ea;
    ea = 2'b00;
    if (own >= 0) begin
      chk("bus_addr", s_addr, cur.addr);
      chk("bus_wen", s_wen, cur.wen);
      chk("bus_wdata", s_wdata, cur.wdata);
      ea[own] = s_ready;
    end else begin
      chk("idle_addr", s_addr, 0);
      chk("idle_wen", s_wen, 0);
      chk("idle_wdata", s_wdata, 0);
    end
    chk("ack", {m1_ack, m0_ack}, ea);
    chk("err", {m1_err, m0_err}, 0);
    chk("rdata0", m0_rdata, ea[0] ? s_rdata : '0);
    chk("rdata1", m1_rdata, ea[1] ? s_rdata : '0);
    chk("stall", {m1_stall, m0_stall}, req & ~ea);
    if (own >= 0) begin
      if (s_ready) begin
        last = (own == 1);
        own  = -1;
      end
    end else if (req != 2'b00) begin
      if (req == 2'b11) own = last ? 0 : 1;
      else own = req[1] ? 1 : 0;
      if (own == 0 && q0.size() > 0) begin
        cur = q0.pop_front();
      end else if (own == 1 && q1.size() > 0) begin
        cur = q1.pop_front();
      end else begin
        chk("sb_has_txn", 0, 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) mon_step();
  end

  task automatic slave_run();
    int streak;
    streak = 0;
    while (!rnd_done) begin
      @(posedge clk);
      #1;
      s_ready = (streak >= 4) || ($urandom_range(2) != 0);
      streak  = s_ready ? 0 : streak + 1;
      s_rdata = $urandom;
    end
  endtask

  task automatic master_run(input int x, input int n);
    txn_t t;
    bit   got;
    for (int i = 0; i < n; i++) begin
      repeat (1 + $urandom_range(3)) @(posedge clk);
      #1;
      t.addr  = $urandom;
      t.wen   = 1'($urandom_range(1));
      t.wdata = $urandom;
      if (x == 0) q0.push_back(t);
      else q1.push_back(t);
      addr[x]  = t.addr;
      wen[x]   = t.wen;
      wdata[x] = t.wdata;
      req[x]   = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        got = (x == 0) ? m0_ack : m1_ack;
      end
      if (!got) chk("ack_wait", 0, 1);
      @(posedge clk);
      #1;
      req[x] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ord[$];
    logic [1:0] a;
    int         pulses;
    rst_n    = 1'b0;
    req      = 2'b00;
    wen      = 2'b00;
    addr[0]  = '0;
    addr[1]  = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    s_ready  = 1'b0;
    s_rdata  = '0;
    #3;
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wen", s_wen, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_acks", {m1_ack, m0_ack}, 0);
    chk("rst_errs", {m1_err, m0_err}, 0);
    chk("rst_stalls", {m1_stall, m0_stall}, 0);
    req[0] = 1'b1;
    #1;
    chk("rst_stall_follows_req", m0_stall, 1);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-wait read by m0.
    @(posedge clk);
    #1;
    addr[0] = 32'h1000;
    wen[0]  = 1'b0;
    req[0]  = 1'b1;
    s_ready = 1'b1;
    s_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rd_ack_early", m0_ack, 0);
    chk("rd_stall_t0", m0_stall, 1);
    @(negedge clk);
    chk("rd_ack", m0_ack, 1);
    chk("rd_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_s_addr", s_addr, 32'h1000);
    chk("rd_stall_t1", m0_stall, 0);
    @(posedge clk);
    #1;
    req[0]  = 1'b0;
    s_ready = 1'b0;
    @(negedge clk);
    chk("rd_ack_after", m0_ack, 0);
    chk("rd_stall_after", m0_stall, 0);

    // Both masters contend continuously from reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    s_ready = 1'b1;
    req     = 2'b11;
    for (int c = 0; c < 60 && ord.size() < 8; c++) begin
      @(negedge clk);
      a = {m1_ack, m0_ack};
      if (a == 2'b11) chk("rr_double_ack", a, 2'b01);
      if (a != 2'b00) ord.push_back(m1_ack ? 1 : 0);
      @(posedge clk);
      #1;
      req = ~a;
    end
    req     = 2'b00;
    s_ready = 1'b0;
    chk("rr_grants", ord.size(), 8);
    foreach (ord[i]) chk("rr_order", ord[i], i % 2);
    @(posedge clk);
    #1;

    // m1 write with three wait states.
    addr[1]  = 32'hFFFF_F000;
    wdata[1] = 32'h20;
    wen[1]   = 1'b1;
    req[1]   = 1'b1;
    pulses   = 0;
    @(negedge clk);
    chk("ws_idle_ack", m1_ack, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      s_ready = (k == 3);
      @(negedge clk);
      chk("ws_s_wen", s_wen, 1);
      chk("ws_s_addr", s_addr, 32'hFFFF_F000);
      chk("ws_s_wdata", s_wdata, 32'h20);
      chk("ws_ack", m1_ack, k == 3);
      chk("ws_m0_stall", m0_stall, 0);
      if (m1_ack) pulses++;
    end
    @(posedge clk);
    #1;
    req[1]  = 1'b0;
    s_ready = 1'b0;
    @(negedge clk);
    chk("ws_ack_after", m1_ack, 0);
    chk("ws_pulses", pulses, 1);

    // Reset while m1 owns the bus mid-write.
    @(posedge clk);
    #1;
    req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rm_gnt1_wen", s_wen, 1);
    #1;
    s_ready = 1'b1;
    #1;
    chk("rm_ack_before", m1_ack, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_wen_drop", s_wen, 0);
    chk("rm_ack_drop", m1_ack, 0);
    chk("rm_addr_drop", s_addr, 0);
    req     = 2'b11;
    wen[0]  = 1'b0;
    s_rdata = 32'hA5A5_0001;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_idle_acks", {m1_ack, m0_ack}, 0);
    @(negedge clk);
    chk("rm_first_gnt", {m1_ack, m0_ack}, 2'b01);
    @(posedge clk);
    #1;
    req     = 2'b00;
    s_ready = 1'b0;
    @(posedge clk);
    #1;

`ifdef DBUS_TIMEOUT_EN
    // Slave never answers: grant aborts on the 15th cycle.
    addr[0] = 32'h80;
    wen[0]  = 1'b1;
    req[0]  = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k < 15) begin
        chk("to_ack_early", m0_ack, 0);
        chk("to_wen_early", s_wen, 1);
      end else begin
        chk("to_ack", m0_ack, 1);
        chk("to_err", m0_err, 1);
        chk("to_rdata", m0_rdata, 0);
        chk("to_wen_forced", s_wen, 0);
      end
    end
    @(posedge clk);
    #1;
    req[0]  = 1'b0;
    req[1]  = 1'b1;
    wen[1]  = 1'b0;
    s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("to_next_ack", m1_ack, 1);
    chk("to_next_err", m1_err, 0);
    chk("to_next_rdata", m1_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    req[1]  = 1'b0;
    s_ready = 1'b0;
`else
    // Slave never answers: grant is held indefinitely.
    addr[0] = 32'h40;
    wen[0]  = 1'b1;
    req[0]  = 1'b1;
    pulses  = 0;
    repeat (101) begin
      @(negedge clk);
      if (m0_ack || m0_err) pulses++;
    end
    chk("nto_no_ack", pulses, 0);
    chk("nto_err", m0_err, 0);
    chk("nto_held_addr", s_addr, 32'h40);
    chk("nto_stall", m0_stall, 1);
    @(posedge clk);
    #1;
    s_ready = 1'b1;
    @(negedge clk);
    chk("nto_release_ack", m0_ack, 1);
    @(posedge clk);
    #1;
    req[0]  = 1'b0;
    s_ready = 1'b0;
`endif

    // Randomized traffic from both masters.
    rst_n = 1'b0;
    req   = 2'b00;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    own    = -1;
    last   = 1'b1;
    mon_en = 1'b1;
    fork
      slave_run();
    join_none
    fork
      master_run(0, 40);
      master_run(1, 40);
    join
    rnd_done = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);
    chk("model_idle", own, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
